// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall hold, flush-to-bubble and saturating
// stall/flush event counters for performance debug.

module EnableFlop #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

module if_id_stage_reg #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               if_valid,
    input  logic               clr_cnt,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic               slot_en;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_d;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_d;
    logic               valid_q;

    logic               stall_inc;
    logic               flush_inc;
    logic               stall_cnt_en;
    logic               flush_cnt_en;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q;

    // A flush overrides a stall, so the slot is written whenever either
    // the pipeline advances or a squash arrives; bubbles are always all-zero.
    assign slot_en = ~stall | flush;

    always_comb begin
        pc_d    = '0;
        instr_d = '0;
        valid_d = 1'b0;
        if (!flush && if_valid) begin
            pc_d    = if_pc;
            instr_d = if_instr;
            valid_d = 1'b1;
        end
    end

    EnableFlop #(.W(PC_W)) u_pc_flop (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (slot_en),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    EnableFlop #(.W(INSTR_W)) u_instr_flop (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (slot_en),
        .d_i    (instr_d),
        .q_o    (instr_q)
    );

    EnableFlop #(.W(1)) u_valid_flop (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (slot_en),
        .d_i    (valid_d),
        .q_o    (valid_q)
    );

    // Events only count when they act on a real instruction in the slot.
    assign stall_inc = stall & ~flush & valid_q & (stall_cnt_q != CntMax);
    assign flush_inc = flush & valid_q & (flush_cnt_q != CntMax);

    assign stall_cnt_en = clr_cnt | stall_inc;
    assign flush_cnt_en = clr_cnt | flush_inc;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    EnableFlop #(.W(CNT_W)) u_stall_cnt_flop (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (stall_cnt_en),
        .d_i    (stall_cnt_d),
        .q_o    (stall_cnt_q)
    );

    EnableFlop #(.W(CNT_W)) u_flush_cnt_flop (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (flush_cnt_en),
        .d_i    (flush_cnt_d),
        .q_o    (flush_cnt_q)
    );

    assign id_pc     = pc_q;
    assign id_instr  = instr_q;
    assign id_valid  = valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg using 4-bit counters so that
// saturation is reachable in a handful of cycles.

module tb_if_id_stage_reg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_valid;
    logic               clr_cnt;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int checks;
    int failures;

    if_id_stage_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_valid  (if_valid),
        .clr_cnt   (clr_cnt),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_valid  (id_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic v,
                                 input logic [PC_W-1:0] pc,
                                 input logic [INSTR_W-1:0] ins,
                                 input logic clr);
        stall    = st;
        flush    = fl;
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        clr_cnt  = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkSlot(input string tag, input logic [PC_W-1:0] pc,
                             input logic [INSTR_W-1:0] ins, input logic v);
        checkOutput({tag, "_pc"}, 64'(id_pc), 64'(pc));
        checkOutput({tag, "_instr"}, 64'(id_instr), 64'(ins));
        checkOutput({tag, "_valid"}, 64'(id_valid), 64'(v));
    endtask

    task automatic checkCounters(input string tag, input int sc, input int fc);
        checkOutput({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(sc));
        checkOutput({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(fc));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        $display("[TB] reset and first load");
        step();
        step();
        checkSlot("reset", '0, '0, 1'b0);
        checkCounters("reset", 0, 0);

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h100, 32'h8B02_0020, 1'b0);
        step();
        checkSlot("load0", 64'h100, 32'h8B02_0020, 1'b1);

        $display("[TB] stall hold");
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h104, 32'h1111_0104, 1'b0);
        step();
        checkSlot("load1", 64'h104, 32'h1111_0104, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h108, 32'h1111_0108, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h10C, 32'h1111_010C, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h110, 32'h1111_0110, 1'b0);
        step();
        checkSlot("stall3", 64'h104, 32'h1111_0104, 1'b1);
        checkCounters("stall3", 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h110, 32'h1111_0110, 1'b0);
        step();
        checkSlot("release", 64'h110, 32'h1111_0110, 1'b1);
        checkCounters("release", 3, 0);

        $display("[TB] flush priority");
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h114, 32'h1111_0114, 1'b0);
        step();
        checkSlot("stallflush", '0, '0, 1'b0);
        checkCounters("stallflush", 3, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h118, 32'h1111_0118, 1'b0);
        step();
        checkSlot("flushempty", '0, '0, 1'b0);
        checkCounters("flushempty", 3, 1);

        $display("[TB] saturation and clear");
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h120, 32'h2222_0120, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h124, 32'h2222_0124, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checkSlot("sat", 64'h120, 32'h2222_0120, 1'b1);
        checkCounters("sat", 15, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h124, 32'h2222_0124, 1'b1);
        step();
        checkCounters("clr", 0, 0);
        checkSlot("clr", 64'h120, 32'h2222_0120, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h124, 32'h2222_0124, 1'b0);
        step();
        checkCounters("afterclr", 1, 0);

        $display("[TB] async reset mid-operation");
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h128, 32'h2222_0128, 1'b0);
        step();
        checkCounters("preflush", 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h180, 32'h3333_0180, 1'b0);
        step();
        checkSlot("prereset", 64'h180, 32'h3333_0180, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkSlot("asyncreset", '0, '0, 1'b0);
        checkCounters("asyncreset", 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h190, 32'h3333_0190, 1'b0);
        step();
        checkSlot("heldreset", '0, '0, 1'b0);
        checkCounters("heldreset", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h200, 32'h4444_0200, 1'b0);
        step();
        checkSlot("postreset", 64'h200, 32'h4444_0200, 1'b1);
        checkCounters("postreset", 0, 0);

        $display("[TB] bubble propagation");
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h300, 32'hFFFF_FFFF, 1'b0);
        step();
        checkSlot("bubble", '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h304, 32'h5555_0304, 1'b0);
        step();
        checkSlot("stallempty", '0, '0, 1'b0);
        checkCounters("stallempty", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
IF/ID pipeline register for the pipelined CPU. It captures the fetched PC/instruction pair at the end of IF and presents it to ID one cycle later. It supports a hazard-unit stall (hold) and a branch-resolution flush (bubble insertion). It also keeps saturating stall and flush event counters for performance debug.

Parameters:
PC_W, 64, width of program counter
INSTR_W, 32, width of instruction word
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  hazard unit hold request; stage keeps current contents
flush  input  1  branch/exception squash; stage becomes a bubble
if_pc  input  PC_W  PC of instruction fetched this cycle
if_instr  input  INSTR_W  instruction fetched this cycle
if_valid  input  1  fetch slot holds a real instruction
clr_cnt  input  1  synchronous clear of both counters
id_pc  output  PC_W  registered PC presented to ID
id_instr  output  INSTR_W  registered instruction presented to ID
id_valid  output  1  ID slot holds a real instruction
stall_cnt  output  CNT_W  cycles spent stalled while holding a valid instruction
flush_cnt  output  CNT_W  flush events that killed a valid instruction

Behaviour:
- Reset assertion (reset=0) is asynchronous and clears state immediately, independent of clk:
  - id_pc=0, id_instr=0, id_valid=0
  - stall_cnt=0, flush_cnt=0
- Reset deassertion: the first capture occurs on the first rising edge with reset=1.
- Reset asserted mid-stall or mid-flush overrides everything; no counter increments on that edge.
- Latency is 1 cycle: inputs sampled at edge N appear on id_* after edge N.
- Slot state is encoded by id_valid: EMPTY (0) or FULL (1).
- Per-edge priority is flush > stall > load:
  - flush=1: id_valid<=0, id_instr<=0, id_pc<=0. The slot goes to EMPTY regardless of stall or if_valid.
  - flush=0, stall=1: id_pc, id_instr and id_valid hold. A held EMPTY slot stays EMPTY.
  - flush=0, stall=0: id_pc<=if_pc, id_instr<=if_instr, id_valid<=if_valid.
  - When if_valid=0 on a load, id_instr<=0 and id_pc<=0, so bubbles are always all-zero.
- Simultaneous stall and flush: flush wins. The stall counter does not increment.
- stall_cnt:
  - +1 on an edge where stall=1, flush=0 and id_valid=1 (pre-edge value).
  - Saturates at 2^CNT_W-1; no wrap.
- flush_cnt:
  - +1 on an edge where flush=1 and id_valid=1 (pre-edge value).
  - Flushing an EMPTY slot is not counted. Saturates at 2^CNT_W-1; no wrap.
- clr_cnt=1: both counters go to 0 on that edge. clr_cnt beats any increment on the same edge. It does not affect the pipeline slot.
- Storage:
  - All storage is built from the codebase's write-enabled flip-flop cells.
  - The slot write enable is (~stall | flush). The next-data mux selects zeros on flush.
- No combinational path from any input to any output.

Test Plan:
- Reset then load: reset=0 for 2 cycles → all outputs 0. Release, drive if_pc=0x100, if_instr=0x8B020020, if_valid=1, stall=flush=0 → after next edge id_pc=0x100, id_instr=0x8B020020, id_valid=1.
- Stall hold: slot FULL with pc 0x104. stall=1 for 3 edges while if_pc changes 0x108/0x10C/0x110 → id_pc stays 0x104, stall_cnt=3. Release stall → id_pc=0x110 next edge.
- Flush priority: slot FULL. stall=1 and flush=1 on the same edge → id_valid=0, id_instr=0, id_pc=0, flush_cnt=1, stall_cnt unchanged. Flush again while EMPTY → flush_cnt stays 1.
- Counter saturation and clear (CNT_W=4):
  - 20 stall edges with FULL slot → stall_cnt=15.
  - clr_cnt=1 with stall=1 → stall_cnt=0 after the edge.
  - Next stall edge → 1.
- Async reset mid-operation: slot FULL, counters nonzero. Drop reset between edges → outputs go 0 before the next clk edge. Raise reset with if_valid=1, if_pc=0x200 → id_pc=0x200 after the first edge.
- Bubble propagation: if_valid=0 with if_instr=0xFFFFFFFF, stall=flush=0 → id_valid=0, id_instr=0, id_pc=0.
